axil_lite_master: RTL and testbench

- AXI4-Lite initiator that turns single-word command requests into AXI-Lite write or read transactions.
- Drives the s_axil_* slave port of the register block. Lets on-chip control logic (the BCH test sequencer, or a UART/JTAG bridge) program and poll registers without an external bus master.
- Only one transaction is outstanding at a time. Responses are returned on a valid/ready response channel.

---
 rtl/axil_pkg.sv | 20 ++
 rtl/axil_lite_master.sv | 168 ++++++++++++++++
 tb/tb_axil_lite_master.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite types and constants for the on-chip register-access master.
package axil_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        WR_ADDR_DATA = 3'd1,
        WR_RESP      = 3'd2,
        RD_ADDR      = 3'd3,
        RD_DATA      = 3'd4,
        RESP         = 3'd5
    } axil_mst_state_t;

    localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXIL_RESP_DECERR = 2'b11;

    localparam logic [2:0] AXIL_PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/axil_lite_master.sv
// Single-outstanding AXI4-Lite initiator: one command in, one AXI transaction out,
// one response back on a valid/ready channel.
//
// state        | meaning
// IDLE         | cmd_ready high, waiting for a command
// WR_ADDR_DATA | AW and W offered, each dropped on its own handshake
// WR_RESP      | bready high, waiting for B
// RD_ADDR      | arvalid high, waiting for arready
// RD_DATA      | rready high, waiting for R
// RESP         | rsp_valid held until rsp_ready
module axil_lite_master
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 21,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    output logic                    busy,
    output logic [7:0]              err_count,
    output logic                    m_axil_awvalid,
    input  logic                    m_axil_awready,
    output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
    output logic [2:0]              m_axil_awprot,
    output logic                    m_axil_wvalid,
    input  logic                    m_axil_wready,
    output logic [DATA_WIDTH-1:0]   m_axil_wdata,
    output logic [DATA_WIDTH/8-1:0] m_axil_wstrb,
    input  logic                    m_axil_bvalid,
    output logic                    m_axil_bready,
    input  logic [1:0]              m_axil_bresp,
    output logic                    m_axil_arvalid,
    input  logic                    m_axil_arready,
    output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
    output logic [2:0]              m_axil_arprot,
    input  logic                    m_axil_rvalid,
    output logic                    m_axil_rready,
    input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
    input  logic [1:0]              m_axil_rresp
);

    axil_mst_state_t         state, state_nxt;
    logic                    aw_done, w_done;
    logic                    aw_ok, w_ok;
    logic                    err_hit;
    logic [ADDR_WIDTH-1:0]   addr_q;

    assign cmd_ready     = (state == IDLE);
    assign busy          = (state != IDLE);
    assign m_axil_awaddr = addr_q;
    assign m_axil_araddr = addr_q;
    assign m_axil_awprot = AXIL_PROT_DEFAULT;
    assign m_axil_arprot = AXIL_PROT_DEFAULT;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A channel counts as done in the very cycle its handshake happens.
    always_comb begin
        aw_ok     = aw_done | (m_axil_awvalid & m_axil_awready);
        w_ok      = w_done  | (m_axil_wvalid  & m_axil_wready);
        err_hit   = ((state == WR_RESP) && m_axil_bvalid && (m_axil_bresp != AXIL_RESP_OKAY)) ||
                    ((state == RD_DATA) && m_axil_rvalid && (m_axil_rresp != AXIL_RESP_OKAY));
        state_nxt = state;
        case (state)
            IDLE:         if (cmd_valid) state_nxt = cmd_write ? WR_ADDR_DATA : RD_ADDR;
            WR_ADDR_DATA: if (aw_ok && w_ok) state_nxt = WR_RESP;
            WR_RESP:      if (m_axil_bvalid) state_nxt = RESP;
            RD_ADDR:      if (m_axil_arready) state_nxt = RD_DATA;
            RD_DATA:      if (m_axil_rvalid) state_nxt = RESP;
            RESP:         if (rsp_ready) state_nxt = IDLE;
            default:      state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q         <= '0;
            m_axil_wdata   <= '0;
            m_axil_wstrb   <= '0;
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid  <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
            aw_done        <= 1'b0;
            w_done         <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_write      <= 1'b0;
            rsp_rdata      <= '0;
            rsp_resp       <= '0;
            err_count      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr_q       <= cmd_addr;
                        m_axil_wdata <= cmd_wdata;
                        m_axil_wstrb <= cmd_wstrb;
                        aw_done      <= 1'b0;
                        w_done       <= 1'b0;
                        if (cmd_write) begin
                            m_axil_awvalid <= 1'b1;
                            m_axil_wvalid  <= 1'b1;
                        end else begin
                            m_axil_arvalid <= 1'b1;
                        end
                    end
                end
                WR_ADDR_DATA: begin
                    if (m_axil_awvalid && m_axil_awready) begin
                        m_axil_awvalid <= 1'b0;
                        aw_done        <= 1'b1;
                    end
                    if (m_axil_wvalid && m_axil_wready) begin
                        m_axil_wvalid <= 1'b0;
                        w_done        <= 1'b1;
                    end
                    if (aw_ok && w_ok) m_axil_bready <= 1'b1;
                end
                WR_RESP: begin
                    if (m_axil_bvalid) begin
                        m_axil_bready <= 1'b0;
                        rsp_valid     <= 1'b1;
                        rsp_write     <= 1'b1;
                        rsp_rdata     <= '0;
                        rsp_resp      <= m_axil_bresp;
                    end
                end
                RD_ADDR: begin
                    if (m_axil_arready) begin
                        m_axil_arvalid <= 1'b0;
                        m_axil_rready  <= 1'b1;
                    end
                end
                RD_DATA: begin
                    if (m_axil_rvalid) begin
                        m_axil_rready <= 1'b0;
                        rsp_valid     <= 1'b1;
                        rsp_write     <= 1'b0;
                        rsp_rdata     <= m_axil_rdata;
                        rsp_resp      <= m_axil_rresp;
                    end
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
            // Saturate rather than wrap so a long error burst stays visible.
            if (err_hit && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_axil_lite_master.sv
// Directed + randomized bench: latency-programmable AXI-Lite responder and an
// associative-array reference model of register contents and error count.
module tb_axil_lite_master;
    import axil_pkg::*;

    localparam int AW = 21;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_write;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          busy;
    logic [7:0]    err_count;
    logic          m_axil_awvalid, m_axil_awready;
    logic [AW-1:0] m_axil_awaddr;
    logic [2:0]    m_axil_awprot;
    logic          m_axil_wvalid, m_axil_wready;
    logic [31:0]   m_axil_wdata;
    logic [3:0]    m_axil_wstrb;
    logic          m_axil_bvalid, m_axil_bready;
    logic [1:0]    m_axil_bresp;
    logic          m_axil_arvalid, m_axil_arready;
    logic [AW-1:0] m_axil_araddr;
    logic [2:0]    m_axil_arprot;
    logic          m_axil_rvalid, m_axil_rready;
    logic [31:0]   m_axil_rdata;
    logic [1:0]    m_axil_rresp;

    axil_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy), .err_count(err_count),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready), .m_axil_bresp(m_axil_bresp),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    int model_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_true(input string tag, input logic cond);
        n_tests++;
        assert (cond === 1'b1) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected 1", tag, cond);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nd,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = nd[8*i +: 8];
        return r;
    endfunction

    // ---------------- responder ----------------
    int          aw_lat = 0, w_lat = 0, ar_lat = 0, b_lat = 0, r_lat = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    logic        aw_got = 0, w_got = 0, b_pend = 0, r_pend = 0;
    logic [AW-1:0] aw_q = '0;
    logic [31:0] w_q = '0, r_data = '0;
    logic [3:0]  ws_q = '0;
    logic [31:0] bfm_mem [logic [AW-1:0]];
    int          b_hs_cnt = 0, aw_hs_e = 0, w_hs_e = 0;
    logic        aw_hs, w_hs, ar_hs;
    logic [AW-1:0] wa;
    logic [31:0] wd;
    logic [3:0]  wsb;

    assign m_axil_awready = (aw_cnt >= aw_lat);
    assign m_axil_wready  = (w_cnt >= w_lat);
    assign m_axil_arready = (ar_cnt >= ar_lat);
    assign m_axil_bvalid  = b_pend && (b_cnt >= b_lat);
    assign m_axil_bresp   = cfg_bresp;
    assign m_axil_rvalid  = r_pend && (r_cnt >= r_lat);
    assign m_axil_rdata   = r_data;
    assign m_axil_rresp   = cfg_rresp;

    always @(posedge clk) begin
        if (rst) begin
            aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; b_cnt <= 0; r_cnt <= 0;
            aw_got <= 0; w_got <= 0; b_pend <= 0; r_pend <= 0;
        end else begin
            aw_hs = m_axil_awvalid && m_axil_awready;
            w_hs  = m_axil_wvalid && m_axil_wready;
            ar_hs = m_axil_arvalid && m_axil_arready;
            if (aw_hs) begin
                chk_true("single_outstanding_aw", !(b_pend || r_pend || aw_got));
                aw_cnt <= 0; aw_got <= 1; aw_q <= m_axil_awaddr; aw_hs_e = cyc + 1;
            end else if (m_axil_awvalid) aw_cnt <= aw_cnt + 1;
            if (w_hs) begin
                chk_true("single_outstanding_w", !(b_pend || r_pend || w_got));
                w_cnt <= 0; w_got <= 1; w_q <= m_axil_wdata; ws_q <= m_axil_wstrb; w_hs_e = cyc + 1;
            end else if (m_axil_wvalid) w_cnt <= w_cnt + 1;
            if ((aw_got || aw_hs) && (w_got || w_hs)) begin
                wa  = aw_hs ? m_axil_awaddr : aw_q;
                wd  = w_hs ? m_axil_wdata : w_q;
                wsb = w_hs ? m_axil_wstrb : ws_q;
                bfm_mem[wa] = merge(bfm_mem.exists(wa) ? bfm_mem[wa] : 32'h0, wd, wsb);
                aw_got <= 0; w_got <= 0; b_pend <= 1; b_cnt <= 0;
            end
            if (m_axil_bvalid && m_axil_bready) begin
                b_pend <= 0; b_hs_cnt++;
            end else if (b_pend) b_cnt <= b_cnt + 1;
            if (ar_hs) begin
                chk_true("single_outstanding_ar", !(b_pend || r_pend || aw_got || w_got));
                r_pend <= 1; r_cnt <= 0; ar_cnt <= 0;
                r_data <= bfm_mem.exists(m_axil_araddr) ? bfm_mem[m_axil_araddr] : 32'h0;
            end else if (m_axil_arvalid) ar_cnt <= ar_cnt + 1;
            if (m_axil_rvalid && m_axil_rready) r_pend <= 0;
            else if (r_pend) r_cnt <= r_cnt + 1;
        end
    end

    int   aw_only_cnt = 0, bready_rise = 0;
    logic bready_prev = 0;
    always @(negedge clk) begin
        if (m_axil_awvalid && !m_axil_wvalid) aw_only_cnt++;
        if (m_axil_bready && !bready_prev) bready_rise = cyc;
        bready_prev = m_axil_bready;
    end

    // ---------------- reference model + driver ----------------
    logic [31:0] ref_mem [logic [AW-1:0]];

    // Called at a negedge; returns at the negedge after the response handshake.
    task automatic run_cmd(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [3:0] s, input bit keep, input int hold,
                           input bit pulse, input bit chk_lat);
        logic        e_wr;
        logic [31:0] e_rd;
        logic [1:0]  e_resp;
        int t, hs;
        cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
        t = 0;
        while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
        chk_true("cmd_accept", cmd_ready);
        if (!cmd_ready) begin cmd_valid = 1'b0; return; end
        @(posedge clk);
        e_wr = wr;
        if (wr) begin
            ref_mem[a] = merge(ref_mem.exists(a) ? ref_mem[a] : 32'h0, d, s);
            e_rd = 32'h0; e_resp = cfg_bresp;
        end else begin
            e_rd = ref_mem.exists(a) ? ref_mem[a] : 32'h0; e_resp = cfg_rresp;
        end
        @(negedge clk);
        if (!keep) cmd_valid = 1'b0;
        hs = cyc;
        if (chk_lat) begin
            if (wr) chk_true("awvalid_wvalid_cycle1", m_axil_awvalid && m_axil_wvalid);
            else    chk_true("arvalid_cycle1", m_axil_arvalid);
            @(negedge clk);
            if (wr) chk_true("bready_cycle2", m_axil_bready);
            else    chk_true("rready_cycle2", m_axil_rready);
        end
        t = 0;
        while (!rsp_valid && t < 300) begin @(negedge clk); t++; end
        chk_true("rsp_valid_seen", rsp_valid);
        if (!rsp_valid) return;
        if (chk_lat) chk("rsp_latency", 32'(cyc - hs + 1), 32'd3);
        if (e_resp != 2'b00 && model_err < 255) model_err++;
        chk("rsp_write", 32'(rsp_write), 32'(e_wr));
        chk("rsp_rdata", rsp_rdata, e_rd);
        chk("rsp_resp", 32'(rsp_resp), 32'(e_resp));
        chk("err_count", 32'(err_count), 32'(model_err));
        for (int i = 0; i < hold; i++) begin
            if (pulse) cmd_valid = (i == 1);
            @(negedge clk);
            chk_true("hold_rsp_valid", rsp_valid);
            chk("hold_rsp_write", 32'(rsp_write), 32'(e_wr));
            chk("hold_rsp_rdata", rsp_rdata, e_rd);
            chk("hold_rsp_resp", 32'(rsp_resp), 32'(e_resp));
            chk_true("hold_cmd_ready_low", !cmd_ready);
        end
        if (pulse) cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, t;
        logic [31:0] rd;
        rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_true("reset_cmd_ready", cmd_ready);
        chk_true("reset_busy_low", !busy);
        chk_true("reset_valids_low", !(m_axil_awvalid | m_axil_wvalid | m_axil_arvalid |
                                       m_axil_bready | m_axil_rready | rsp_valid));
        chk("reset_err_count", 32'(err_count), 32'd0);
        chk("reset_awaddr", 32'(m_axil_awaddr), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("awprot", 32'(m_axil_awprot), 32'd0);
        chk("arprot", 32'(m_axil_arprot), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: zero-wait write then read
        run_cmd(1'b1, 21'h000004, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1);
        run_cmd(1'b0, 21'h000004, 32'h0, 4'h0, 0, 0, 0, 1);

        // 2: W accepted three cycles before AW
        aw_lat = 3; aw_only_cnt = 0; b0 = b_hs_cnt;
        run_cmd(1'b1, 21'h000010, 32'hA5A5_0F0F, 4'hF, 0, 0, 0, 0);
        chk("aw_after_w_gap", 32'(aw_hs_e - w_hs_e), 32'd3);
        chk("aw_only_cycles", 32'(aw_only_cnt), 32'd3);
        chk("bready_after_both", 32'(bready_rise), 32'(aw_hs_e));
        chk("one_b_response", 32'(b_hs_cnt - b0), 32'd1);
        aw_lat = 0;

        // 4: response back-pressure with an ignored command pulse, then strobe check
        run_cmd(1'b1, 21'h000020, 32'h1234_5678, 4'b0101, 0, 5, 1, 0);
        chk_true("idle_after_hold", !busy && cmd_ready);
        @(negedge clk);
        chk_true("pulse_not_accepted", !busy);
        run_cmd(1'b0, 21'h000020, 32'h0, 4'h0, 0, 0, 0, 0);

        // 3: error responses and saturation
        cfg_rresp = AXIL_RESP_SLVERR;
        for (int i = 0; i < 3; i++) run_cmd(1'b0, 21'h000004, 32'h0, 4'h0, 0, 0, 0, 0);
        chk("err_count_three", 32'(err_count), 32'd3);
        cfg_bresp = AXIL_RESP_DECERR;
        for (int i = 0; i < 260; i++)
            run_cmd(i[0], AW'(32'h100 + 4 * (i % 16)), $urandom, 4'hF, 0, 0, 0, 0);
        chk("err_count_saturated", 32'(err_count), 32'd255);
        cfg_bresp = AXIL_RESP_OKAY; cfg_rresp = AXIL_RESP_OKAY;

        // 5: reset while waiting on a withheld B
        b_lat = 1000;
        cmd_write = 1'b1; cmd_addr = 21'h0007FC; cmd_wdata = 32'hCAFE_F00D; cmd_wstrb = 4'hF;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        t = 0;
        while (!m_axil_bready && t < 20) begin @(negedge clk); t++; end
        chk_true("wr_resp_reached", m_axil_bready);
        repeat (4) @(negedge clk);
        chk_true("hung_busy", busy);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_true("abort_cmd_ready", cmd_ready);
        chk_true("abort_busy_low", !busy);
        chk_true("abort_valids_low", !(m_axil_awvalid | m_axil_wvalid | m_axil_arvalid |
                                       m_axil_bready | m_axil_rready | rsp_valid));
        chk("abort_err_count", 32'(err_count), 32'd0);
        rst = 1'b0; model_err = 0; b_lat = 0;
        @(negedge clk);

        // 6: back-to-back, cmd_valid held, random responder timing and codes
        for (int i = 0; i < 8; i++) begin
            aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3);
            ar_lat = $urandom_range(0, 3); b_lat = $urandom_range(0, 3);
            r_lat = $urandom_range(0, 3);
            cfg_bresp = 2'($urandom_range(0, 3)); cfg_rresp = 2'($urandom_range(0, 3));
            rd = $urandom;
            run_cmd(i < 4, AW'(32'h200 + 4 * (i % 4)), rd, 4'($urandom_range(1, 15)), 1,
                    $urandom_range(0, 3), 0, 0);
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("final_err_count", 32'(err_count), 32'(model_err));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
